// File: rtl/seq_long_divider.sv
// Multi-cycle unsigned restoring long divider: Q = D / M, R = D % M, one quotient bit per clock.
// Start/done handshake, registered results held until the next done, divide-by-zero flag.
module seq_long_divider #(
  parameter int DW = 8,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] D,
  input  logic [MW-1:0] M,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] Q,
  output logic [MW-1:0] R,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    r_state;
  logic [DW-1:0] r_dsr;
  logic [MW:0]   r_pr;
  logic [DW-1:0] r_quo;
  logic [MW-1:0] r_m;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_q;
  logic [MW-1:0] r_r;
  logic          r_dz;

  logic [MW:0]   w_pr_sh;
  logic          w_ge;
  logic [MW:0]   w_pr_nx;
  logic [DW-1:0] w_quo_nx;

  // One restoring step: shift the next dividend bit into pr, subtract M when it fits.
  always_comb begin
    w_pr_sh  = (r_pr << 1) | {{MW{1'b0}}, r_dsr[DW-1]};
    w_ge     = (w_pr_sh >= {1'b0, r_m});
    w_pr_nx  = w_ge ? (w_pr_sh - {1'b0, r_m}) : w_pr_sh;
    w_quo_nx = (r_quo << 1) | {{(DW-1){1'b0}}, w_ge};
  end

  // FSM, datapath and registered outputs; results are written on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dsr   <= '0;
      r_pr    <= '0;
      r_quo   <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_m <= M;
            if (M != '0) begin
              r_dsr   <= D;
              r_pr    <= '0;
              r_quo   <= '0;
              r_cnt   <= CW'(DW);
              r_busy  <= 1'b1;
              r_state <= RUN;
            end else begin
              r_done  <= 1'b1;
              r_q     <= {DW{1'b1}};
              r_r     <= D[MW-1:0];
              r_dz    <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_dsr <= r_dsr << 1;
          r_pr  <= w_pr_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
          // Last quotient bit: publish the result directly from the step logic.
          if (r_cnt == CW'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_q     <= w_quo_nx;
            r_r     <= w_pr_nx[MW-1:0];
            r_dz    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_long_divider.sv
// Bench for seq_long_divider: directed scenarios on an 8/4 instance, random sweep on a 16/8 instance,
// all checked against plain / and % arithmetic.
module tb_seq_long_divider;

  logic clk = 1'b0;
  logic rst;

  logic       s8;
  logic [7:0] d8;
  logic [3:0] m8;
  logic       b8, dn8, z8;
  logic [7:0] q8;
  logic [3:0] r8;

  logic        s16;
  logic [15:0] d16;
  logic [7:0]  m16;
  logic        b16, dn16, z16;
  logic [15:0] q16;
  logic [7:0]  r16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_long_divider #(.DW(8), .MW(4)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .D(d8), .M(m8),
    .busy(b8), .done(dn8), .Q(q8), .R(r8), .div_by_zero(z8)
  );

  seq_long_divider #(.DW(16), .MW(8)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .D(d16), .M(m16),
    .busy(b16), .done(dn16), .Q(q16), .R(r16), .div_by_zero(z16)
  );

  task automatic test_reset();
    rst = 1'b1; s8 = 1'b0; d8 = 8'd0; m8 = 4'd0; s16 = 1'b0; d16 = 16'd0; m16 = 8'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({b8, dn8, q8, r8, z8} !== 15'd0) begin
      n_bad++; $display("FAIL reset8 got b=%0b d=%0b q=%0d r=%0d z=%0b want all 0", b8, dn8, q8, r8, z8);
    end
    n_cmp++;
    if ({b16, dn16, q16, r16, z16} !== 27'd0) begin
      n_bad++; $display("FAIL reset16 got b=%0b d=%0b q=%0d r=%0d z=%0b want all 0", b16, dn16, q16, r16, z16);
    end
    rst = 1'b0;
  endtask

  // Issue one divide on the 8/4 instance and check result, latency, busy length and pulse width.
  task automatic div8(input logic [7:0] d, input logic [3:0] m, input string tag);
    logic [7:0] eq; logic [3:0] er; logic ez;
    int elat, ebusy, lat, bcnt;
    if (m == 4'd0) begin
      eq = 8'hFF; er = d[3:0]; ez = 1'b1; elat = 1; ebusy = 0;
    end else begin
      eq = d / {4'd0, m}; er = 4'(d % {4'd0, m}); ez = 1'b0; elat = 9; ebusy = 8;
    end
    @(negedge clk); s8 = 1'b1; d8 = d; m8 = m;
    @(negedge clk); s8 = 1'b0; d8 = 8'($urandom); m8 = 4'($urandom);
    lat = 1; bcnt = 0;
    while (!dn8 && lat < 40) begin
      if (b8) bcnt++;
      @(negedge clk); lat++;
    end
    n_cmp++;
    if (lat !== elat) begin n_bad++; $display("FAIL %s latency got %0d want %0d", tag, lat, elat); end
    n_cmp++;
    if (q8 !== eq) begin n_bad++; $display("FAIL %s Q got %0d want %0d (D=%0d M=%0d)", tag, q8, eq, d, m); end
    n_cmp++;
    if (r8 !== er) begin n_bad++; $display("FAIL %s R got %0d want %0d (D=%0d M=%0d)", tag, r8, er, d, m); end
    n_cmp++;
    if (z8 !== ez) begin n_bad++; $display("FAIL %s div_by_zero got %0b want %0b", tag, z8, ez); end
    n_cmp++;
    if (bcnt !== ebusy) begin n_bad++; $display("FAIL %s busy cycles got %0d want %0d", tag, bcnt, ebusy); end
    n_cmp++;
    if (b8 !== 1'b0) begin n_bad++; $display("FAIL %s busy with done got %0b want 0", tag, b8); end
    @(negedge clk);
    n_cmp++;
    if (dn8 !== 1'b0) begin n_bad++; $display("FAIL %s done pulse width got done=%0b want 0", tag, dn8); end
  endtask

  task automatic test_basic();
    div8(8'd7, 4'd2, "basic_7_2");
  endtask

  task automatic test_patterns();
    div8(8'd12, 4'd5, "pat_12_5");
    div8(8'd255, 4'd1, "pat_255_1");
    div8(8'd255, 4'd15, "pat_255_15");
    for (int i = 0; i < 20; i++) div8(8'($urandom), 4'($urandom), "rand8");
  endtask

  task automatic test_div_zero();
    div8(8'd200, 4'd0, "dz_200");
  endtask

  task automatic test_start_ignored_and_back_to_back();
    int lat, held_bad;
    @(negedge clk); s8 = 1'b1; d8 = 8'd7; m8 = 4'd2;
    @(negedge clk); s8 = 1'b0;
    @(negedge clk);
    @(negedge clk); s8 = 1'b1; d8 = 8'd100; m8 = 4'd3;
    @(negedge clk); s8 = 1'b0;
    @(negedge clk); s8 = 1'b1; d8 = 8'd250; m8 = 4'd0;
    @(negedge clk); s8 = 1'b0;
    lat = 6;
    while (!dn8 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL ignore latency got %0d want 9", lat); end
    n_cmp++;
    if ({q8, r8, z8} !== {8'd3, 4'd1, 1'b0}) begin
      n_bad++; $display("FAIL ignore result got Q=%0d R=%0d z=%0b want Q=3 R=1 z=0", q8, r8, z8);
    end
    s8 = 1'b1; d8 = 8'd9; m8 = 4'd4;
    @(negedge clk); s8 = 1'b0;
    lat = 1; held_bad = 0;
    while (!dn8 && lat < 40) begin
      if (q8 !== 8'd3 || r8 !== 4'd1) held_bad++;
      @(negedge clk); lat++;
    end
    n_cmp++;
    if (held_bad !== 0) begin n_bad++; $display("FAIL b2b hold got %0d changed cycles want 0", held_bad); end
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL b2b latency got %0d want 9", lat); end
    n_cmp++;
    if ({q8, r8, z8} !== {8'd2, 4'd1, 1'b0}) begin
      n_bad++; $display("FAIL b2b result got Q=%0d R=%0d z=%0b want Q=2 R=1 z=0", q8, r8, z8);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int dcnt;
    @(negedge clk); s8 = 1'b1; d8 = 8'd50; m8 = 4'd7;
    @(negedge clk); s8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({b8, dn8, q8, r8, z8} !== 15'd0) begin
      n_bad++; $display("FAIL midrst got b=%0b d=%0b q=%0d r=%0d z=%0b want all 0", b8, dn8, q8, r8, z8);
    end
    rst = 1'b0;
    dcnt = 0;
    repeat (12) begin @(negedge clk); if (dn8 || b8) dcnt++; end
    n_cmp++;
    if (dcnt !== 0) begin n_bad++; $display("FAIL midrst activity got %0d cycles want 0", dcnt); end
    div8(8'd50, 4'd7, "post_rst");
  endtask

  task automatic test_sweep16();
    logic [15:0] d, eq; logic [7:0] m, er;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      m = 8'($urandom_range(1, 255));
      if (i == 0) begin d = 16'hFFFF; m = 8'd1; end
      if (i == 1) begin d = 16'd0; m = 8'd255; end
      if (i == 2) begin d = 16'hFFFF; m = 8'd255; end
      eq = d / {8'd0, m};
      er = 8'(d % {8'd0, m});
      @(negedge clk); s16 = 1'b1; d16 = d; m16 = m;
      @(negedge clk); s16 = 1'b0; d16 = 16'($urandom);
      lat = 1;
      while (!dn16 && lat < 60) begin @(negedge clk); lat++; end
      n_cmp++;
      if (lat !== 17) begin n_bad++; $display("FAIL sweep16 latency got %0d want 17 (D=%0d M=%0d)", lat, d, m); end
      n_cmp++;
      if (q16 !== eq || r16 !== er || z16 !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep16 result got Q=%0d R=%0d z=%0b want Q=%0d R=%0d z=0 (D=%0d M=%0d)",
                 q16, r16, z16, eq, er, d, m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_start_ignored_and_back_to_back();
    test_reset_mid_run();
    test_sweep16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
